// File: rtl/stack_unit.sv
// stack_unit: operand stack for the stack-machine datapath.
// Executes push/pop/tos strobes with a registered top-of-stack output.
// Tracks occupancy and traps overflow/underflow into a sticky FAULT state.
// Optional feature macro: STACK_BYPASS_EN forwards din to dout on tos+push.
module stack_unit #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              tos,
   input  logic [DATA_W-1:0] din,
   input  logic              clr_err,
   output logic [DATA_W-1:0] dout,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf,
   output logic              fault
);

`ifdef STACK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;
   localparam logic [1:0] ST_FAULT   = 2'd3;

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W:0]    sp_q, sp_d;
   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  top_idx;
   logic              is_empty, is_full;
   logic              ovf_evt, unf_evt;

   // Occupancy-derived state used when leaving FAULT or after a legal op.
   function automatic logic [1:0] state_for(input logic [PTR_W:0] n);
      if (n == '0)
         return ST_EMPTY;
      else if (n == DEPTH_C)
         return ST_FULL;
      else
         return ST_PARTIAL;
   endfunction

   assign top_idx  = PTR_W'(sp_q - 1'b1);
   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == DEPTH_C);

   // A push that cannot land (full, no paired pop) is an overflow; any pop
   // or a tos with nothing to read (unless bypass supplies din) underflows.
   assign ovf_evt = push & ~pop & is_full;
   assign unf_evt = is_empty & (pop | (tos & ~(BYPASS & push)));

   // Next-state logic: clr_err first, then FAULT freeze, then error trap,
   // otherwise the normal push/pop/replace and tos read.
   always_comb begin
      sp_d    = sp_q;
      state_d = state_q;
      dout_d  = dout_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = sp_q[PTR_W-1:0];

      if (clr_err) begin
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
         state_d = state_for(sp_q);
      end else if (state_q == ST_FAULT) begin
         // Stack frozen; tos may still read a valid top.
         if (tos && !is_empty)
            dout_d = mem_q[top_idx];
      end else if (ovf_evt || unf_evt) begin
         // Offending operation blocked; sp and array stay put.
         ovf_d   = ovf_q | ovf_evt;
         unf_d   = unf_q | unf_evt;
         state_d = ST_FAULT;
         if (tos && !is_empty)
            dout_d = mem_q[top_idx];
      end else begin
         if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
         end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + 1'b1;
         end else if (pop) begin
            sp_d = sp_q - 1'b1;
         end
         if (tos)
            dout_d = (BYPASS && push) ? din : mem_q[top_idx];
         state_d = state_for(sp_d);
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sp_q    <= '0;
         state_q <= ST_EMPTY;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         state_q <= state_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage; not reset, and writes are dropped during reset.
   always_ff @(posedge clk) begin
      if (reset && wr_en)
         mem_q[wr_idx] <= din;
   end

   assign dout  = dout_q;
   assign count = sp_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;
   assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed-vector self-checking bench for stack_unit.
module tb_stack_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       push, pop, tos, clr_err;
   logic [7:0] din;
   logic [7:0] dout;
   logic [4:0] count;
   logic       empty, full, ovf, unf, fault;

   int n_checks = 0;
   int n_pass   = 0;

   stack_unit #(.DATA_W(8), .DEPTH(16), .PTR_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .tos     (tos),
      .din     (din),
      .clr_err (clr_err),
      .dout    (dout),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .ovf     (ovf),
      .unf     (unf),
      .fault   (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
         $display("check %-12s obs=0x%0h exp=0x%0h ok", tag, obs, exp_v);
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock with the given strobes; outputs are sampled 1 time unit
   // after the edge, then strobes drop.
   task automatic step(input logic ps, input logic pp, input logic ts,
                       input logic [7:0] d, input logic ce);
      push = ps; pop = pp; tos = ts; din = d; clr_err = ce;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic [4:0] c, input logic e,
                              input logic f, input logic o, input logic u, input logic flt);
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".empty"}, 32'(empty), 32'(e));
      check({tag, ".full"},  32'(full),  32'(f));
      check({tag, ".ovf"},   32'(ovf),   32'(o));
      check({tag, ".unf"},   32'(unf),   32'(u));
      check({tag, ".fault"}, 32'(fault), 32'(flt));
   endtask

   initial begin
      push = 0; pop = 0; tos = 0; din = 0; clr_err = 0; reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_flags("rst", 5'd0, 1, 0, 0, 0, 0);
      check("rst.dout", 32'(dout), 32'h0);
      reset = 1'b1;

      // Push three, then read top.
      step(1, 0, 0, 8'h11, 0);
      step(1, 0, 0, 8'h22, 0);
      step(1, 0, 0, 8'h33, 0);
      step(0, 0, 1, 8'h00, 0);
      check("tos3.dout", 32'(dout), 32'h33);
      check_flags("tos3", 5'd3, 0, 0, 0, 0, 0);

      // Read-and-discard three times.
      step(0, 1, 1, 8'h00, 0);
      check("tp1.dout", 32'(dout), 32'h33);
      step(0, 1, 1, 8'h00, 0);
      check("tp2.dout", 32'(dout), 32'h22);
      step(0, 1, 1, 8'h00, 0);
      check("tp3.dout", 32'(dout), 32'h11);
      check_flags("tp3", 5'd0, 1, 0, 0, 0, 0);

      // Fill to 16, then overflow.
      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h40 + i), 0);
      check_flags("fill", 5'd16, 0, 1, 0, 0, 0);
      step(1, 0, 0, 8'hAA, 0);
      check_flags("ovf", 5'd16, 0, 1, 1, 0, 1);
      step(0, 0, 1, 8'h00, 0);
      check("ovf.top", 32'(dout), 32'h4F);
      step(0, 1, 0, 8'h00, 0);
      check("fltpop.count", 32'(count), 32'd16);
      step(0, 0, 0, 8'h00, 1);
      check_flags("clr1", 5'd16, 0, 1, 0, 0, 0);
      // Replace-top is legal when FULL.
      step(1, 1, 0, 8'h77, 0);
      step(0, 0, 1, 8'h00, 0);
      check("fullrep.dout", 32'(dout), 32'h77);
      check_flags("fullrep", 5'd16, 0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00, 0);
      check_flags("drain", 5'd0, 1, 0, 0, 0, 0);

      // Underflow from EMPTY.
      step(0, 1, 0, 8'h00, 0);
      check_flags("unf", 5'd0, 1, 0, 0, 1, 1);
      check("unf.dout", 32'(dout), 32'h77);
      step(0, 0, 0, 8'h00, 1);
      check_flags("clr2", 5'd0, 1, 0, 0, 0, 0);

      // tos+push from EMPTY.
      step(1, 0, 1, 8'h5A, 0);
`ifdef STACK_BYPASS_EN
      check_flags("tpe", 5'd1, 0, 0, 0, 0, 0);
      check("tpe.dout", 32'(dout), 32'h5A);
      step(0, 1, 0, 8'h00, 0);
`else
      check_flags("tpe", 5'd0, 1, 0, 0, 1, 1);
      check("tpe.dout", 32'(dout), 32'h77);
      step(0, 0, 0, 8'h00, 1);
`endif
      check_flags("tpe2", 5'd0, 1, 0, 0, 0, 0);

      // Replace top with tos at count=2.
      step(1, 0, 0, 8'h03, 0);
      step(1, 0, 0, 8'h05, 0);
      step(1, 1, 1, 8'h09, 0);
`ifdef STACK_BYPASS_EN
      check("rep.dout", 32'(dout), 32'h09);
`else
      check("rep.dout", 32'(dout), 32'h05);
`endif
      check("rep.count", 32'(count), 32'd2);
      step(0, 0, 1, 8'h00, 0);
      check("rep.newtop", 32'(dout), 32'h09);
      step(0, 1, 1, 8'h00, 0);
      step(0, 0, 1, 8'h00, 0);
      check("rep.under", 32'(dout), 32'h03);
      check("rep.count1", 32'(count), 32'd1);

      // Reset mid-operation at count=5 with a concurrent push.
      for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hC0 + i), 0);
      check("pre.count", 32'(count), 32'd5);
      reset = 1'b0;
      step(1, 0, 1, 8'hEE, 0);
      reset = 1'b1;
      check_flags("mrst", 5'd0, 1, 0, 0, 0, 0);
      check("mrst.dout", 32'(dout), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
